// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: stateful back end of the 0x8xxx_xxxx MMIO region.
//   Owns the cycle/instruction counters and the button-event store, and turns
//   CPU loads/stores into UART transmit/receive strobes.
// Build option: define IO_MMIO_BTN_FIFO_EN for a BTN_FIFO_DEPTH-entry button
//   FIFO; otherwise a single-entry holding register (newest press wins).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   addr, wdata, we, re        MEM-stage access (we/re one cycle per access)
//   inst_retire                one instruction committed this cycle
//   trmt_full                  UART transmitter cannot accept data
//   buttons_in                 one-cycle press pulses
//   trmt_data, trmt_valid      registered transmit byte and strobe
//   recv_pop                   registered receive-byte consume strobe
//   counter_cycle/inst         free-running cycle and retired-instruction counts
//   buttons_empty, buttons     button store empty flag and show-ahead head
module io_mmio_ctrl #(
  parameter int unsigned BTN_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  input  logic        trmt_full,
  input  logic [2:0]  buttons_in,
  output logic [7:0]  trmt_data,
  output logic        trmt_valid,
  output logic        recv_pop,
  output logic [31:0] counter_cycle,
  output logic [31:0] counter_inst,
  output logic        buttons_empty,
  output logic [2:0]  buttons
);

  localparam logic [3:0] REGION      = 4'h8;
  localparam logic [5:0] OFF_RX      = 6'h04;
  localparam logic [5:0] OFF_TX      = 6'h08;
  localparam logic [5:0] OFF_CNT_CLR = 6'h18;
  localparam logic [5:0] OFF_BTN     = 6'h24;

  // Address decode; only addr[5:0] selects the register within the region.
  logic       hit;
  logic [5:0] off;
  logic       tx_c, rx_c, clr_c, btn_pop_c, btn_push_c;

  assign hit        = (addr[31:28] == REGION);
  assign off        = addr[5:0];
  assign tx_c       = we && hit && (off == OFF_TX) && !trmt_full;
  assign rx_c       = re && hit && (off == OFF_RX);
  assign clr_c      = we && hit && (off == OFF_CNT_CLR);
  assign btn_pop_c  = re && hit && (off == OFF_BTN);
  assign btn_push_c = (buttons_in != 3'b000);

  // Address/data bits outside the decode are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{addr[27:6], wdata[31:8], 8'(BTN_FIFO_DEPTH)};

  // UART strobes: one-cycle pulses the cycle after the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt_data  <= 8'h00;
      trmt_valid <= 1'b0;
      recv_pop   <= 1'b0;
    end else begin
      trmt_valid <= tx_c;
      recv_pop   <= rx_c;
      if (tx_c) trmt_data <= wdata[7:0];
    end
  end

  // Counters; a clear wins over the increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_cycle <= 32'h0;
      counter_inst  <= 32'h0;
    end else if (clr_c) begin
      counter_cycle <= 32'h0;
      counter_inst  <= 32'h0;
    end else begin
      counter_cycle <= counter_cycle + 32'h1;
      if (inst_retire) counter_inst <= counter_inst + 32'h1;
    end
  end

`ifdef IO_MMIO_BTN_FIFO_EN
  localparam int unsigned AW = $clog2(BTN_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [2:0]    mem [BTN_FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0] count, count_mid, count_nxt;
  logic          pop_ok, push_ok;
  logic [2:0]    head_nxt;

  // Pop first so a full FIFO can accept a push in the same cycle; the head
  // output is precomputed so it stays registered yet show-ahead.
  always_comb begin
    pop_ok     = btn_pop_c && (count != '0);
    push_ok    = btn_push_c && ((count != CW'(BTN_FIFO_DEPTH)) || pop_ok);
    rd_ptr_nxt = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
    count_mid  = pop_ok ? count - CW'(1) : count;
    count_nxt  = push_ok ? count_mid + CW'(1) : count_mid;
    head_nxt   = 3'b000;
    if (count_mid == '0) begin
      if (push_ok) head_nxt = buttons_in;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      buttons       <= 3'b000;
      buttons_empty <= 1'b1;
    end else begin
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      buttons       <= head_nxt;
      buttons_empty <= (count_nxt == '0);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Storage needs no reset: validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= buttons_in;
  end
`else
  // Single holding register: a new press overwrites any unread one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buttons       <= 3'b000;
      buttons_empty <= 1'b1;
    end else if (btn_push_c) begin
      buttons       <= buttons_in;
      buttons_empty <= 1'b0;
    end else if (btn_pop_c) begin
      buttons       <= 3'b000;
      buttons_empty <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Bench for io_mmio_ctrl: vector table for single-cycle decode behaviour,
// a transmit scoreboard, a button-store model and hand sequences for
// counters, wrap and asynchronous reset.
module tb_io_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        we = 1'b0, re = 1'b0, inst_retire = 1'b0, trmt_full = 1'b0;
  logic [2:0]  buttons_in = '0;
  logic [7:0]  trmt_data;
  logic        trmt_valid, recv_pop, buttons_empty;
  logic [31:0] counter_cycle, counter_inst;
  logic [2:0]  buttons;

  always #5 clk = ~clk;

  io_mmio_ctrl dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .inst_retire(inst_retire), .trmt_full(trmt_full), .buttons_in(buttons_in),
    .trmt_data(trmt_data), .trmt_valid(trmt_valid), .recv_pop(recv_pop),
    .counter_cycle(counter_cycle), .counter_inst(counter_inst),
    .buttons_empty(buttons_empty), .buttons(buttons)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Transmit scoreboard: expected bytes queued when the store is driven.
  logic [7:0] tx_q[$];
  always @(negedge clk) begin
    if (trmt_valid) begin
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_spurious: got strobe data 0x%02h want no strobe", trmt_data);
      end else begin
        check("tx_data", 32'(trmt_data), 32'(tx_q.pop_front()));
      end
    end
  end

  // Button store model.
  logic [2:0] bq[$];
  function automatic void model_btn(input logic push, input logic [2:0] d, input logic pop);
`ifdef IO_MMIO_BTN_FIFO_EN
    if (pop && bq.size() != 0) void'(bq.pop_front());
    if (push && bq.size() < 8) bq.push_back(d);
`else
    if (push) begin
      bq.delete();
      bq.push_back(d);
    end else if (pop) begin
      bq.delete();
    end
`endif
  endfunction

  task automatic check_btn(input string name);
    check({name, "_empty"}, 32'(buttons_empty), 32'(bq.size() == 0));
    check({name, "_head"}, 32'(buttons), 32'((bq.size() == 0) ? 3'b000 : bq[0]));
  endtask

  // One cycle of stimulus, applied at a falling edge, returning idle inputs.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic r, input logic [2:0] b, input logic ret);
    addr = a; wdata = d; we = w; re = r; buttons_in = b; inst_retire = ret;
    model_btn(b != 3'b000, b, r && (a == 32'h8000_0024));
    @(negedge clk);
    addr = '0; wdata = '0; we = 1'b0; re = 1'b0; buttons_in = '0; inst_retire = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] d;
    logic        w, r, f;
    logic [2:0]  b;
    logic        e_valid, e_pop, e_empty;
    logic [2:0]  e_btn;
  } vec_t;

  localparam int unsigned NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic r, input logic f, input logic [2:0] b,
                              input logic ev, input logic ep, input logic ee, input logic [2:0] eb);
    vec_t v;
    v.name = n; v.a = a; v.d = d; v.w = w; v.r = r; v.f = f; v.b = b;
    v.e_valid = ev; v.e_pop = ep; v.e_empty = ee; v.e_btn = eb;
    return v;
  endfunction

  logic [2:0] push_seq[9];

  initial begin
    vecs[0]  = mk("idle",          32'h0000_0000, 32'h0,         0, 0, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[1]  = mk("tx",            32'h8000_0008, 32'h41,        1, 0, 0, 3'd0, 1, 0, 1, 3'd0);
    vecs[2]  = mk("tx_full",       32'h8000_0008, 32'h55,        1, 0, 1, 3'd0, 0, 0, 1, 3'd0);
    vecs[3]  = mk("rx",            32'h8000_0004, 32'h0,         0, 1, 0, 3'd0, 0, 1, 1, 3'd0);
    vecs[4]  = mk("tx_outside",    32'h0000_0008, 32'h66,        1, 0, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[5]  = mk("rx_outside",    32'h9000_0004, 32'h0,         0, 1, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[6]  = mk("rx_wrongoff",   32'h8000_0010, 32'h0,         0, 1, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[7]  = mk("st_rxoff",      32'h8000_0004, 32'h77,        1, 0, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[8]  = mk("push5",         32'h0000_0000, 32'h0,         0, 0, 0, 3'd5, 0, 0, 0, 3'd5);
    vecs[9]  = mk("hold5",         32'h0000_0000, 32'h0,         0, 0, 0, 3'd0, 0, 0, 0, 3'd5);
    vecs[10] = mk("pop5",          32'h8000_0024, 32'h0,         0, 1, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[11] = mk("pop_empty",     32'h8000_0024, 32'h0,         0, 1, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[12] = mk("pushpop_empty", 32'h8000_0024, 32'h0,         0, 1, 0, 3'd2, 0, 0, 0, 3'd2);
    vecs[13] = mk("pushpop",       32'h8000_0024, 32'h0,         0, 1, 0, 3'd6, 0, 0, 0, 3'd6);
    vecs[14] = mk("pop_last",      32'h8000_0024, 32'h0,         0, 1, 0, 3'd0, 0, 0, 1, 3'd0);
    vecs[15] = mk("tx_alias",      32'h8000_0048, 32'h7E,        1, 0, 0, 3'd0, 1, 0, 1, 3'd0);
    vecs[16] = mk("tx_hibits",     32'h8000_0008, 32'hFFFF_FF9A, 1, 0, 0, 3'd0, 1, 0, 1, 3'd0);
    vecs[17] = mk("rx_alias",      32'h8ABC_DE44, 32'h0,         0, 1, 0, 3'd0, 0, 1, 1, 3'd0);

    push_seq[0] = 3'd1; push_seq[1] = 3'd2; push_seq[2] = 3'd3;
    push_seq[3] = 3'd4; push_seq[4] = 3'd5; push_seq[5] = 3'd6;
    push_seq[6] = 3'd7; push_seq[7] = 3'd1; push_seq[8] = 3'd2;

    // Reset values, then 10 idle cycles after release.
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(trmt_valid), 32'd0);
    check("rst_data", 32'(trmt_data), 32'd0);
    check("rst_pop", 32'(recv_pop), 32'd0);
    check("rst_empty", 32'(buttons_empty), 32'd1);
    check("rst_btn", 32'(buttons), 32'd0);
    check("rst_cycle", counter_cycle, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle10_cycle", counter_cycle, 32'd10);
    check("idle10_inst", counter_inst, 32'd0);
    check("idle10_empty", 32'(buttons_empty), 32'd1);
    check("idle10_valid", 32'(trmt_valid), 32'd0);

    // Single-cycle decode vectors, back to back.
    for (int i = 0; i < int'(NV); i++) begin
      addr = vecs[i].a; wdata = vecs[i].d; we = vecs[i].w; re = vecs[i].r;
      trmt_full = vecs[i].f; buttons_in = vecs[i].b;
      if (vecs[i].e_valid) tx_q.push_back(vecs[i].d[7:0]);
      @(negedge clk);
      addr = '0; wdata = '0; we = 1'b0; re = 1'b0; trmt_full = 1'b0; buttons_in = '0;
      check({vecs[i].name, "_valid"}, 32'(trmt_valid), 32'(vecs[i].e_valid));
      check({vecs[i].name, "_pop"}, 32'(recv_pop), 32'(vecs[i].e_pop));
      check({vecs[i].name, "_empty"}, 32'(buttons_empty), 32'(vecs[i].e_empty));
      check({vecs[i].name, "_btn"}, 32'(buttons), 32'(vecs[i].e_btn));
    end
    @(negedge clk);
    check("strobe_clear_valid", 32'(trmt_valid), 32'd0);
    check("strobe_clear_pop", 32'(recv_pop), 32'd0);

    // Button overflow, full push+pop, and drain; model starts empty.
    bq.delete();
    for (int i = 0; i < 9; i++) begin
      cyc(32'h0, 32'h0, 1'b0, 1'b0, push_seq[i], 1'b0);
      check_btn($sformatf("push%0d", i));
    end
    for (int i = 0; i < 9; i++) begin
      cyc(32'h8000_0024, 32'h0, 1'b0, 1'b1, (i == 0) ? 3'd4 : 3'd0, 1'b0);
      check_btn($sformatf("drain%0d", i));
    end
    check("drained_empty", 32'(buttons_empty), 32'd1);
    check("drained_btn", 32'(buttons), 32'd0);

    // Counter clear beats a simultaneous retire.
    cyc(32'h8000_0024, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    check("inst3", counter_inst, 32'd3);
    cyc(32'h8000_0018, 32'hDEAD_BEEF, 1'b1, 1'b0, 3'd0, 1'b1);
    check("clr_cycle", counter_cycle, 32'd0);
    check("clr_inst", counter_inst, 32'd0);
    cyc(32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    check("clr_cycle_p1", counter_cycle, 32'd1);
    check("clr_inst_p1", counter_inst, 32'd1);

    // Cycle counter wrap.
    force dut.counter_cycle = 32'hFFFF_FFFE;
    #1 release dut.counter_cycle;
    @(negedge clk);
    check("wrap_max", counter_cycle, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_zero", counter_cycle, 32'd0);

    // Asynchronous reset in mid-cycle with a strobe and a press pending.
    addr = 32'h8000_0008; wdata = 32'h33; we = 1'b1; buttons_in = 3'd3; inst_retire = 1'b1;
    @(posedge clk);
    addr = '0; wdata = '0; we = 1'b0; buttons_in = '0; inst_retire = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(trmt_valid), 32'd0);
    check("arst_data", 32'(trmt_data), 32'd0);
    check("arst_pop", 32'(recv_pop), 32'd0);
    check("arst_cycle", counter_cycle, 32'd0);
    check("arst_inst", counter_inst, 32'd0);
    check("arst_empty", 32'(buttons_empty), 32'd1);
    check("arst_btn", 32'(buttons), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cycle", counter_cycle, 32'd1);
    check("post_rst_empty", 32'(buttons_empty), 32'd1);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
